highlight_overlay: RTL

- Consumer end of the highlight FIFO.
- Drains the 8-bit reduced-region highlight stream and the full-frame 24-bit RGB image stream in lock-step raster order.
- Emits the composited RGB frame to the display/output FIFO.
- Pixels inside the reduced region whose highlight byte is nonzero are recoloured; all other pixels pass through unchanged.

---
 rtl/highlight_overlay.sv | 118 +++++++++++
 1 files changed

// File: rtl/highlight_overlay.sv
// Highlight FIFO consumer: composites the reduced-region highlight stream onto the full RGB frame.
// Optional macro HIGHLIGHT_OVERLAY_BLEND_EN averages highlighted pixels with HIGHLIGHT_COLOR instead of replacing them.
module highlight_overlay #(
  parameter int          WIDTH           = 640,
  parameter int          HEIGHT          = 360,
  parameter int          STARTING_X      = 0,
  parameter int          STARTING_Y      = 0,
  parameter int          ENDING_X        = 568,
  parameter int          ENDING_Y        = 320,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] image_dout,
  input  logic        image_empty,
  output logic        image_rd_en,
  input  logic [7:0]  highlight_dout,
  input  logic        highlight_empty,
  output logic        highlight_rd_en,
  output logic [23:0] out_din,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic        frame_done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_frame_done;

  int            w_xi;
  int            w_yi;
  logic          w_in_region;
  logic          w_fire;
  logic          w_last_x;
  logic          w_last_y;
  logic [23:0]   w_hl_pixel;

  // Region bounds compared as int so zero-valued bounds do not produce constant unsigned compares.
  assign w_xi        = int'(r_x);
  assign w_yi        = int'(r_y);
  assign w_in_region = (w_xi >= STARTING_X) && (w_xi < ENDING_X) &&
                       (w_yi >= STARTING_Y) && (w_yi < ENDING_Y);
  assign w_last_x    = (w_xi == WIDTH - 1);
  assign w_last_y    = (w_yi == HEIGHT - 1);

  assign w_fire = (r_state == STREAM) && !reset && !image_empty && !out_full &&
                  (!w_in_region || !highlight_empty);

`ifdef HIGHLIGHT_OVERLAY_BLEND_EN
  logic [8:0] w_sum;
  always_comb begin
    w_hl_pixel = '0;
    w_sum      = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      w_sum = {1'b0, image_dout[8*c +: 8]} + {1'b0, HIGHLIGHT_COLOR[8*c +: 8]};
      w_hl_pixel[8*c +: 8] = w_sum[8:1];
    end
  end
`else
  assign w_hl_pixel = HIGHLIGHT_COLOR;
`endif

  always_comb begin
    image_rd_en     = 1'b0;
    highlight_rd_en = 1'b0;
    out_wr_en       = 1'b0;
    out_din         = '0;
    if (w_fire) begin
      image_rd_en     = 1'b1;
      highlight_rd_en = w_in_region;
      out_wr_en       = 1'b1;
      out_din         = (w_in_region && (highlight_dout != '0)) ? w_hl_pixel : image_dout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!image_empty) r_state <= STREAM;
        end
        STREAM: begin
          if (w_fire) begin
            if (w_last_x) begin
              r_x <= '0;
              if (w_last_y) begin
                r_y          <= '0;
                r_state      <= DONE;
                r_frame_done <= 1'b1;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign frame_done = r_frame_done;

endmodule
